// File: rtl/mgmt_uart_tlul.sv
// mgmt_uart_tlul: TL-UL device UART with a TX FIFO, a one-byte RX holding register and a programmable baud divider.
// Define MGMT_UART_LOOPBACK_EN to add the CTRL register (0x10) with internal TX->RX loopback.
module mgmt_uart_tlul #(
    parameter int          TxFifoDepth  = 16,
    parameter logic [15:0] BaudDivReset = 16'd434
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic [85:0] tl_i,
    output logic [51:0] tl_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_rx_o,
    output logic        irq_tx_empty_o
);
    localparam int AW = $clog2(TxFifoDepth);
    localparam logic [2:0] OpPutFull = 3'd0, OpPutPartial = 3'd1, OpGet = 3'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // tl_i packs {a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready}
    logic        a_valid, d_ready;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    assign {a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready} = tl_i;

    logic unused_tl;
    assign unused_tl = ^{a_param, a_mask, a_address[31:5], a_address[1:0]};

    logic        d_valid, d_error;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic [15:0] baud_div;
    logic        rx_valid, overrun, frame_err;
    logic [7:0]  rx_byte;

    logic [7:0]  fifo_mem [TxFifoDepth];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, fifo_push, tx_pop;
    logic [7:0]  fifo_head;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_line, tx_end, tx_idle, irq_en;

    rx_state_t   rx_state;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic [1:0]  rx_sync;
    logic        rx_prev, rx_src, rx_mid, rx_done;

    logic        accept, rsp_err, rx_pop, wr_status, wr_baud, wr_ctrl;
    logic [31:0] rsp_data, status_word;
    logic [2:0]  a_index;

`ifdef MGMT_UART_LOOPBACK_EN
    logic loopback;
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) loopback <= 1'b0;
        else if (wr_ctrl) loopback <= a_data[0];
    end
    assign rx_src    = loopback ? tx_line : rx_sync[1];
    assign uart_tx_o = loopback ? 1'b1 : tx_line;
`else
    assign rx_src    = rx_sync[1];
    assign uart_tx_o = tx_line;
`endif

    assign accept      = a_valid && !d_valid;
    assign a_index     = a_address[4:2];
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head   = fifo_mem[rd_ptr[AW-1:0]];
    assign tx_idle     = (tx_state == TX_IDLE);
    assign status_word = {26'd0, frame_err, overrun, rx_valid, tx_idle, fifo_empty, fifo_full};

    always_comb begin
        rsp_err   = 1'b0;
        rsp_data  = 32'd0;
        fifo_push = 1'b0;
        rx_pop    = 1'b0;
        wr_status = 1'b0;
        wr_baud   = 1'b0;
        wr_ctrl   = 1'b0;
        if (a_opcode != OpGet && a_opcode != OpPutFull && a_opcode != OpPutPartial) begin
            rsp_err = 1'b1;
        end else begin
            case (a_index)
                3'd0: if (a_opcode == OpGet || fifo_full) rsp_err = 1'b1;
                      else fifo_push = accept;
                3'd1: if (a_opcode != OpGet) rsp_err = 1'b1;
                      else begin
                          rsp_data = rx_valid ? {1'b1, 23'd0, rx_byte} : 32'd0;
                          rx_pop   = accept;
                      end
                3'd2: if (a_opcode == OpGet) rsp_data = status_word;
                      else wr_status = accept;
                3'd3: if (a_opcode == OpGet) rsp_data = {16'd0, baud_div};
                      else wr_baud = accept;
`ifdef MGMT_UART_LOOPBACK_EN
                3'd4: if (a_opcode == OpGet) rsp_data = {31'd0, loopback};
                      else wr_ctrl = accept;
`endif
                default: rsp_err = 1'b1;
            endcase
        end
    end

    // Response channel, configuration and the RX holding register; a read pop is applied before a same-cycle byte load
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 2'd0;
            d_source  <= 8'd0;
            d_data    <= 32'd0;
            d_error   <= 1'b0;
            baud_div  <= BaudDivReset;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'd0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept) begin
                d_valid  <= 1'b1;
                d_opcode <= (a_opcode == OpGet) ? 3'd1 : 3'd0;
                d_size   <= a_size;
                d_source <= a_source;
                d_data   <= rsp_err ? 32'd0 : rsp_data;
                d_error  <= rsp_err;
            end else if (d_ready) begin
                d_valid <= 1'b0;
            end
            if (wr_baud) baud_div <= (a_data[15:0] < 16'd16) ? 16'd16 : a_data[15:0];
            if (rx_done) begin
                if (!rx_src) frame_err <= 1'b1;
                if (rx_valid && !rx_pop) begin
                    overrun <= 1'b1;
                end else begin
                    rx_byte  <= rx_shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
            if (wr_status && a_data[4]) overrun <= 1'b0;
            if (wr_status && a_data[5]) frame_err <= 1'b0;
        end
    end

    assign tl_o = {d_valid, d_opcode, 3'd0, d_size, d_source, 1'b0, d_data, d_error, !d_valid};

    always_ff @(posedge clk_sys_i) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= a_data[7:0];
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Bit length is latched at every bit boundary so a BAUDDIV write never stretches the current bit
    assign tx_end = (tx_cnt == tx_div - 16'd1);
    assign tx_pop = !fifo_empty && (tx_idle || (tx_state == TX_STOP && tx_end));

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
            tx_cnt   <= 16'd0;
            tx_div   <= BaudDivReset;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            irq_en   <= 1'b0;
        end else begin
            irq_en <= 1'b1;
            if (tx_idle) begin
                if (tx_pop) begin
                    tx_state <= TX_START;
                    tx_line  <= 1'b0;
                    tx_shift <= fifo_head;
                    tx_cnt   <= 16'd0;
                    tx_div   <= baud_div;
                end
            end else if (tx_end) begin
                tx_cnt <= 16'd0;
                tx_div <= baud_div;
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= 3'd0;
                        tx_line  <= tx_shift[0];
                    end
                    TX_DATA: if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        tx_line  <= 1'b1;
                    end else begin
                        tx_bit  <= tx_bit + 3'd1;
                        tx_line <= tx_shift[tx_bit + 3'd1];
                    end
                    default: if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_line  <= 1'b0;
                        tx_shift <= fifo_head;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                endcase
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    assign rx_mid  = (rx_cnt == rx_div - 16'd1);
    assign rx_done = (rx_state == RX_STOP) && rx_mid;

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_div   <= BaudDivReset;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx_i};
            rx_prev <= rx_src;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_src) begin
                    rx_state <= RX_START;
                    rx_cnt   <= 16'd0;
                    rx_div   <= baud_div;
                end
                RX_START: if (rx_cnt == {1'b0, rx_div[15:1]}) begin
                    rx_state <= rx_src ? RX_IDLE : RX_DATA;
                    rx_cnt   <= 16'd0;
                    rx_bit   <= 3'd0;
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
                RX_DATA: if (rx_mid) begin
                    rx_shift <= {rx_src, rx_shift[7:1]};
                    rx_cnt   <= 16'd0;
                    rx_bit   <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else begin
                    rx_cnt <= rx_cnt + 16'd1;
                end
                default: if (rx_mid) rx_state <= RX_IDLE;
                         else rx_cnt <= rx_cnt + 16'd1;
            endcase
        end
    end

    assign irq_rx_o       = rx_valid;
    assign irq_tx_empty_o = irq_en && fifo_empty && tx_idle;
endmodule

// File: tb/tb_mgmt_uart_tlul.sv
// tb_mgmt_uart_tlul: randomized self-checking bench for mgmt_uart_tlul with a serial frame monitor and byte-level model.
module tb_mgmt_uart_tlul;
    localparam int Depth = 16;
    localparam int Baud  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0;
    logic [2:0]  a_opcode = 3'd0;
    logic [1:0]  a_size = 2'd0;
    logic [7:0]  a_source = 8'd0;
    logic [31:0] a_address = 32'd0;
    logic [3:0]  a_mask = 4'hF;
    logic [31:0] a_data = 32'd0;
    logic        d_ready = 1'b1;
    logic        uart_rx = 1'b1;
    logic [85:0] tl_i;
    logic [51:0] tl_o;
    logic        uart_tx_o, irq_rx_o, irq_tx_empty_o;

    assign tl_i = {a_valid, a_opcode, 3'd0, a_size, a_source, a_address, a_mask, a_data, d_ready};

    logic        d_valid, d_error, a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    assign d_valid  = tl_o[51];
    assign d_opcode = tl_o[50:48];
    assign d_size   = tl_o[44:43];
    assign d_source = tl_o[42:35];
    assign d_data   = tl_o[33:2];
    assign d_error  = tl_o[1];
    assign a_ready  = tl_o[0];

    mgmt_uart_tlul #(.TxFifoDepth(Depth), .BaudDivReset(16'd434)) dut (
        .clk_sys_i(clk),
        .rst_sys_i(rst),
        .tl_i(tl_i),
        .tl_o(tl_o),
        .uart_rx_i(uart_rx),
        .uart_tx_o(uart_tx_o),
        .irq_rx_o(irq_rx_o),
        .irq_tx_empty_o(irq_tx_empty_o)
    );

    int total = 0;
    int bad = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [7:0] mon_bytes[$];
    logic       mon_stops[$];
    int         mon_starts[$];
    logic       mon_prev = 1'b1;
    logic [7:0] mon_b;
    int         mon_t;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Serial monitor: decodes uart_tx_o frames by sampling mid-bit at the nominal bench baud rate
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mon_prev && !uart_tx_o) begin
                mon_t = cycle;
                repeat (Baud / 2) @(negedge clk);
                if (!uart_tx_o) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (Baud) @(negedge clk);
                        mon_b[i] = uart_tx_o;
                    end
                    repeat (Baud) @(negedge clk);
                    mon_bytes.push_back(mon_b);
                    mon_stops.push_back(uart_tx_o);
                    mon_starts.push_back(mon_t);
                end
            end
            mon_prev = uart_tx_o;
        end
    end

    task automatic tl_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                             input int hold, output logic [31:0] rdata, output logic err);
        logic [7:0] src;
        logic [1:0] sz;
        int n;
        src = 8'($urandom);
        sz  = 2'($urandom);
        @(negedge clk);
        d_ready   = (hold == 0);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_address = addr;
        a_data    = wdata;
        a_source  = src;
        a_size    = sz;
        a_mask    = 4'($urandom);
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("a_ready_wait", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        checkOutput("d_valid_next", {31'd0, d_valid}, 32'd1);
        rdata = d_data;
        err   = d_error;
        checkOutput("d_source", {24'd0, d_source}, {24'd0, src});
        checkOutput("d_size", {30'd0, d_size}, {30'd0, sz});
        checkOutput("d_opcode", {29'd0, d_opcode}, (op == 3'd4) ? 32'd1 : 32'd0);
        for (int i = 0; i < hold; i++) begin
            checkOutput("d_hold", {30'd0, d_valid, a_ready}, 32'd2);
            @(negedge clk);
        end
        d_ready = 1'b1;
        @(negedge clk);
        checkOutput("d_drop", {31'd0, d_valid}, 32'd0);
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic [31:0] rd;
        logic err;
        tl_access(3'($urandom_range(0, 1)), addr, data, 0, rd, err);
        checkOutput(tag, {31'd0, err}, 32'd0);
    endtask

    task automatic reg_read(input logic [31:0] addr, output logic [31:0] data, input string tag);
        logic err;
        tl_access(3'd4, addr, 32'd0, 0, data, err);
        checkOutput(tag, {31'd0, err}, 32'd0);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = fr[i];
            repeat (Baud - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k;
        k = 0;
        while (mon_bytes.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frame_count", mon_bytes.size(), n);
    endtask

    logic [31:0] rd, vals[$];
    logic        err;
    logic [7:0]  exp_tx[$];
    logic [7:0]  b1, b2;
    int          k, still_high;

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs", {28'd0, uart_tx_o, d_valid, irq_rx_o, irq_tx_empty_o}, 32'h8);
        checkOutput("rst_a_ready", {31'd0, a_ready}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        reg_read(32'h0C, rd, "baud_rd_err");
        checkOutput("baud_reset", rd, 32'd434);
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("status_reset", rd, 32'h6);

        vals = '{32'd0, 32'd15, 32'd16, 32'd17};
        for (int i = 0; i < 4; i++) vals.push_back(32'($urandom));
        foreach (vals[i]) begin
            reg_write(32'h0C, vals[i], "baud_wr_err");
            reg_read(32'h0C, rd, "baud_rd_err");
            checkOutput("baud_clamp", rd, (vals[i][15:0] < 16) ? 32'd16 : {16'd0, vals[i][15:0]});
        end
        reg_write(32'h0C, Baud, "baud_wr_err");

        // Single frame of 0xA5
        reg_write(32'h00, 32'hA5, "tx_wr_err");
        wait_frames(1, 400);
        if (mon_bytes.size() > 0) begin
            checkOutput("tx_a5_byte", {24'd0, mon_bytes[0]}, 32'hA5);
            checkOutput("tx_a5_stop", {31'd0, mon_stops[0]}, 32'd1);
        end
        k = 0;
        while (!irq_tx_empty_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("irq_tx_empty", {31'd0, irq_tx_empty_o}, 32'd1);
        mon_bytes.delete();
        mon_stops.delete();
        mon_starts.delete();

        // One byte goes straight to the shifter, Depth more fill the FIFO, the next is dropped
        for (int i = 0; i < Depth + 1; i++) begin
            exp_tx.push_back(8'($urandom));
            reg_write(32'h00, {24'd0, exp_tx[i]}, "fill_wr_err");
        end
        tl_access(3'd0, 32'h00, 32'hEE, 3, rd, err);
        checkOutput("full_drop_err", {31'd0, err}, 32'd1);
        checkOutput("full_drop_data", rd, 32'd0);
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("status_full", {29'd0, rd[2:0]}, 32'h1);
        wait_frames(Depth + 1, (Depth + 2) * 10 * Baud + 200);
        for (int i = 0; i < Depth + 1 && i < mon_bytes.size(); i++) begin
            checkOutput("fill_byte", {24'd0, mon_bytes[i]}, {24'd0, exp_tx[i]});
            checkOutput("fill_stop", {31'd0, mon_stops[i]}, 32'd1);
            if (i > 0) checkOutput("back_to_back", mon_starts[i] - mon_starts[i-1], 10 * Baud);
        end
        mon_bytes.delete();
        mon_stops.delete();
        mon_starts.delete();

        // Receive path with random bytes, then the fixed 0x3C frame
        for (int i = 0; i < 4; i++) begin
            b1 = (i == 0) ? 8'h3C : 8'($urandom);
            drive_rx(b1, 1'b1);
            checkOutput("irq_rx", {31'd0, irq_rx_o}, 32'd1);
            reg_read(32'h04, rd, "rx_rd_err");
            checkOutput("rx_data", rd, {1'b1, 23'd0, b1});
            reg_read(32'h04, rd, "rx_rd_err");
            checkOutput("rx_empty", rd, 32'd0);
        end

        // Start bit that is too short is ignored
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * Baud) @(negedge clk);
        checkOutput("rx_glitch", {31'd0, irq_rx_o}, 32'd0);

        b1 = 8'($urandom);
        b2 = 8'($urandom);
        drive_rx(b1, 1'b1);
        drive_rx(b2, 1'b1);
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("ovr_status_rx", {26'd0, rd[5:3], 3'd0}, 32'h18);
        checkOutput("ovr_status_tx", {29'd0, rd[2:0]}, 32'h6);
        reg_write(32'h08, 32'h10, "status_wr_err");
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("ovr_cleared", {26'd0, rd[5:3], 3'd0}, 32'h08);
        reg_read(32'h04, rd, "rx_rd_err");
        checkOutput("ovr_keeps_first", rd, {1'b1, 23'd0, b1});

        b1 = 8'($urandom);
        drive_rx(b1, 1'b0);
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("frame_err_set", {26'd0, rd[5:3], 3'd0}, 32'h28);
        reg_read(32'h04, rd, "rx_rd_err");
        checkOutput("frame_err_byte", rd, {1'b1, 23'd0, b1});
        reg_write(32'h08, 32'h20, "status_wr_err");
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("frame_err_clr", {26'd0, rd[5:3], 3'd0}, 32'h0);

        // Error responses
        tl_access(3'd4, 32'h14, 32'd0, 0, rd, err);
        checkOutput("err_unmapped", {rd[30:0], err}, 32'd1);
        tl_access(3'd0, 32'h04, 32'h55, 0, rd, err);
        checkOutput("err_wr_rxdata", {rd[30:0], err}, 32'd1);
        tl_access(3'd4, 32'h00, 32'd0, 0, rd, err);
        checkOutput("err_rd_txdata", {rd[30:0], err}, 32'd1);
        tl_access(3'd7, 32'h08, 32'd0, 5, rd, err);
        checkOutput("err_opcode", {rd[30:0], err}, 32'd1);

`ifdef MGMT_UART_LOOPBACK_EN
        reg_write(32'h10, 32'd1, "ctrl_wr_err");
        reg_read(32'h10, rd, "ctrl_rd_err");
        checkOutput("ctrl_value", rd, 32'd1);
        reg_write(32'h00, 32'h5A, "tx_wr_err");
        still_high = 1;
        for (int i = 0; i < 12 * Baud; i++) begin
            @(negedge clk);
            if (!uart_tx_o) still_high = 0;
        end
        checkOutput("lb_tx_high", still_high, 32'd1);
        reg_read(32'h04, rd, "rx_rd_err");
        checkOutput("lb_rx_data", rd, 32'h8000005A);
        reg_write(32'h10, 32'd0, "ctrl_wr_err");
`else
        tl_access(3'd4, 32'h10, 32'd0, 0, rd, err);
        checkOutput("err_ctrl_absent", {rd[30:0], err}, 32'd1);
`endif

        // Reset in the middle of a zero byte must release the line at once and flush the FIFO
        reg_write(32'h00, 32'h00, "tx_wr_err");
        reg_write(32'h00, 32'h11, "tx_wr_err");
        reg_write(32'h00, 32'h22, "tx_wr_err");
        repeat (40) @(negedge clk);
        checkOutput("pre_reset_tx", {31'd0, uart_tx_o}, 32'd0);
        #2 rst = 1'b1;
        #1 checkOutput("reset_async", {29'd0, uart_tx_o, d_valid, a_ready}, 32'h5);
        @(negedge clk);
        rst = 1'b0;
        reg_read(32'h08, rd, "status_rd_err");
        checkOutput("reset_flushed", {29'd0, rd[2:0]}, 32'h6);
        still_high = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!uart_tx_o) still_high = 0;
        end
        checkOutput("reset_tx_idle", still_high, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
